// File: rtl/keypad_debounce_if.sv
// Pin-side bundle of the keypad/door conditioner: raw switch inputs in,
// single-cycle key events and debounced door level out.
interface keypad_debounce_if;
    logic [5:0] key_raw_i;
    logic       door_raw_i;
    logic       KEY_0;
    logic       KEY_1;
    logic       KEY_2;
    logic       KEY_3;
    logic       KEY_OK;
    logic       KEY_CLEAR;
    logic       DOOR_SEALED;
    logic       key_busy_o;
    logic       stuck_o;

    // master: board/stimulus side, slave: the conditioner itself
    modport master (
        output key_raw_i, door_raw_i,
        input  KEY_0, KEY_1, KEY_2, KEY_3, KEY_OK, KEY_CLEAR,
        input  DOOR_SEALED, key_busy_o, stuck_o
    );

    modport slave (
        input  key_raw_i, door_raw_i,
        output KEY_0, KEY_1, KEY_2, KEY_3, KEY_OK, KEY_CLEAR,
        output DOOR_SEALED, key_busy_o, stuck_o
    );
endinterface

// File: rtl/keypad_debounce.sv
// Synchronise and debounce six keys plus the door switch; one KEY_* pulse per press.
// Optional held-key alarm on stuck_o when KEYPAD_STUCK_DETECT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no key accepted; next debounced rise emits one KEY_* pulse
// ST_HELD | a key was accepted; wait for all six keys to be released
module keypad_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 1_000_000
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    keypad_debounce_if.slave kif
);

    localparam int NCH   = 7;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("keypad_debounce: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("keypad_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (STUCK_CYCLES < 1) begin : g_bad_stuck
        $error("keypad_debounce: STUCK_CYCLES must be >= 1");
    end

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync_q [SYNC_STAGES];
    logic [NCH-1:0]   sync_last;
    logic [NCH-1:0]   stable_q;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [5:0]       stable_d_q;
    logic [5:0]       rise;
    logic [5:0]       first_rise;
    logic [5:0]       key_pulse_q;
    logic [5:0]       key_pulse_d;
    state_t           state_q;
    state_t           state_d;

    // channel 6 is the door switch, channels 0..5 the keys
    assign raw       = {kif.door_raw_i, kif.key_raw_i};
    assign sync_last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // any sample back at the stable level restarts that channel's count
    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            stable_q   <= '0;
            stable_d_q <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            stable_d_q <= stable_q[5:0];
            for (int ch = 0; ch < NCH; ch++) begin
                if (sync_last[ch] == stable_q[ch]) begin
                    cnt_q[ch] <= '0;
                end else if (cnt_q[ch] == CNT_LAST) begin
                    stable_q[ch] <= sync_last[ch];
                    cnt_q[ch]    <= '0;
                end else begin
                    cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

    assign rise       = stable_q[5:0] & ~stable_d_q;
    // isolate the lowest set bit: digit0 has the highest priority
    assign first_rise = rise & (~rise + 6'd1);

    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            state_q     <= ST_IDLE;
            key_pulse_q <= '0;
        end else begin
            state_q     <= state_d;
            key_pulse_q <= key_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_pulse_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (|rise) begin
                    key_pulse_d = first_rise;
                    state_d     = ST_HELD;
                end
            end
            ST_HELD: begin
                if (stable_q[5:0] == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign kif.KEY_0       = key_pulse_q[0];
    assign kif.KEY_1       = key_pulse_q[1];
    assign kif.KEY_2       = key_pulse_q[2];
    assign kif.KEY_3       = key_pulse_q[3];
    assign kif.KEY_OK      = key_pulse_q[4];
    assign kif.KEY_CLEAR   = key_pulse_q[5];
    assign kif.DOOR_SEALED = stable_q[6];
    assign kif.key_busy_o  = (state_q == ST_HELD);

`ifdef KEYPAD_STUCK_DETECT_EN
    localparam int HELD_W = $clog2(STUCK_CYCLES + 1);

    logic [HELD_W-1:0] held_cnt_q;
    logic              stuck_q;

    // alarm drops in the same cycle the FSM is back in IDLE
    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            held_cnt_q <= '0;
            stuck_q    <= 1'b0;
        end else if (state_d == ST_IDLE) begin
            held_cnt_q <= '0;
            stuck_q    <= 1'b0;
        end else if (state_q == ST_HELD) begin
            if (held_cnt_q != HELD_W'(STUCK_CYCLES)) begin
                held_cnt_q <= held_cnt_q + HELD_W'(1);
            end
            if (held_cnt_q == HELD_W'(STUCK_CYCLES - 1)) begin
                stuck_q <= 1'b1;
            end
        end
    end

    assign kif.stuck_o = stuck_q;
`else
    assign kif.stuck_o = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce: directed press/bounce/door/reset scenarios and
// random traffic, checked against a behavioural model through an event scoreboard.
module tb_keypad_debounce;

    localparam int SYNC  = 2;
    localparam int DEB   = 16;
    localparam int STUCK = 50;

    logic clk_i    = 1'b0;
    logic arst_n_i = 1'b0;

    keypad_debounce_if kif();

    keypad_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .STUCK_CYCLES   (STUCK)
    ) dut (
        .clk_i   (clk_i),
        .arst_n_i(arst_n_i),
        .kif     (kif.slave)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int idx;
        int cyc;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    bit   chk_en   = 1'b0;
    exp_t exp_q[$];

    // behavioural model state
    bit [6:0] m_pipe[$];
    bit [6:0] m_stable;
    bit [5:0] m_stable_prev;
    int       m_run[7];
    bit       m_busy;
    int       m_held;
    bit       m_stuck;

    // monitor bookkeeping used by the directed scenarios
    int pulse_cnt      = 0;
    int last_idx       = -1;
    int last_cyc       = -1;
    int door_rise_cnt  = 0;
    int door_rise_cyc  = -1;
    bit door_prev      = 1'b0;
    int stuck_rise_cnt = 0;
    int stuck_rise_cyc = -1;
    bit stuck_prev     = 1'b0;

    task automatic model_reset();
        m_pipe.delete();
        for (int s = 0; s < SYNC; s++) m_pipe.push_back(7'd0);
        m_stable      = '0;
        m_stable_prev = '0;
        for (int ch = 0; ch < 7; ch++) m_run[ch] = 0;
        m_busy  = 1'b0;
        m_held  = 0;
        m_stuck = 1'b0;
    endtask

    // model: a change is accepted after DEB consecutive differing synced samples
    always @(posedge clk_i) begin
        bit [6:0] raw_s;
        bit [6:0] seen;
        bit [5:0] rise;
        int       lo;
        cyc++;
        raw_s = {kif.door_raw_i, kif.key_raw_i};
        if (!arst_n_i) begin
            model_reset();
            chk_en = 1'b1;
        end else begin
            rise = m_stable[5:0] & ~m_stable_prev;
            if (!m_busy) begin
                if (rise != 6'd0) begin
                    lo = -1;
                    for (int i = 5; i >= 0; i--) if (rise[i]) lo = i;
                    exp_q.push_back('{idx: lo, cyc: cyc});
                    m_busy = 1'b1;
                    m_held = 0;
                end
            end else if (m_stable[5:0] == 6'd0) begin
                m_busy = 1'b0;
                m_held = 0;
            end else begin
                m_held++;
            end
`ifdef KEYPAD_STUCK_DETECT_EN
            m_stuck = m_busy && (m_held >= STUCK);
`else
            m_stuck = 1'b0;
`endif
            m_stable_prev = m_stable[5:0];
            seen = m_pipe.pop_front();
            m_pipe.push_back(raw_s);
            for (int ch = 0; ch < 7; ch++) begin
                if (seen[ch] == m_stable[ch]) begin
                    m_run[ch] = 0;
                end else begin
                    m_run[ch]++;
                    if (m_run[ch] == DEB) begin
                        m_stable[ch] = seen[ch];
                        m_run[ch]    = 0;
                    end
                end
            end
        end
    end

    // monitor: pops expected key events whenever the DUT presents a pulse
    always @(negedge clk_i) begin
        bit [5:0] kv;
        int       idx;
        if (chk_en) begin
            kv = {kif.KEY_CLEAR, kif.KEY_OK, kif.KEY_3, kif.KEY_2, kif.KEY_1, kif.KEY_0};
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL key_missing: no pulse seen, expected key %0d at cycle %0d",
                         exp_q[0].idx, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (kv != 6'd0) begin
                n_checks++;
                idx = -1;
                if ($onehot(kv)) for (int i = 5; i >= 0; i--) if (kv[i]) idx = i;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL key_unexpected: got keys %b at cycle %0d, expected none", kv, cyc);
                end else if (exp_q[0].idx != idx || exp_q[0].cyc != cyc) begin
                    n_errors++;
                    $display("FAIL key_event: got keys %b (idx %0d) at cycle %0d, expected idx %0d at cycle %0d",
                             kv, idx, cyc, exp_q[0].idx, exp_q[0].cyc);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) void'(exp_q.pop_front());
                pulse_cnt++;
                last_idx = idx;
                last_cyc = cyc;
            end
            n_checks++;
            if (kif.key_busy_o !== m_busy) begin
                n_errors++;
                $display("FAIL busy_level: got %b expected %b at cycle %0d", kif.key_busy_o, m_busy, cyc);
            end
            n_checks++;
            if (kif.DOOR_SEALED !== m_stable[6]) begin
                n_errors++;
                $display("FAIL door_level: got %b expected %b at cycle %0d", kif.DOOR_SEALED, m_stable[6], cyc);
            end
            n_checks++;
            if (kif.stuck_o !== m_stuck) begin
                n_errors++;
                $display("FAIL stuck_level: got %b expected %b at cycle %0d", kif.stuck_o, m_stuck, cyc);
            end
            if (kif.DOOR_SEALED && !door_prev) begin
                door_rise_cnt++;
                door_rise_cyc = cyc;
            end
            door_prev = kif.DOOR_SEALED;
            if (kif.stuck_o && !stuck_prev) begin
                stuck_rise_cnt++;
                stuck_rise_cyc = cyc;
            end
            stuck_prev = kif.stuck_o;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    initial begin
        int t0;
        int p0;
        int d0;
        int s0;
        kif.key_raw_i  = 6'd0;
        kif.door_raw_i = 1'b0;
        arst_n_i       = 1'b0;
        step(3);
        check("reset_keys", int'({kif.KEY_CLEAR, kif.KEY_OK, kif.KEY_3, kif.KEY_2, kif.KEY_1, kif.KEY_0}), 0);
        check("reset_door", int'(kif.DOOR_SEALED), 0);
        check("reset_busy", int'(kif.key_busy_o), 0);
        check("reset_stuck", int'(kif.stuck_o), 0);
        arst_n_i = 1'b1;
        step(5);

        // clean press of digit 2
        p0 = pulse_cnt;
        t0 = cyc;
        kif.key_raw_i[2] = 1'b1;
        step(100);
        check("clean_count", pulse_cnt - p0, 1);
        check("clean_idx", last_idx, 2);
        check("clean_latency", last_cyc - t0, 19);
        kif.key_raw_i = 6'd0;
        step(40);

        // bouncing digit 0
        p0 = pulse_cnt;
        for (int k = 0; k < 12; k++) begin
            kif.key_raw_i[0] = ~kif.key_raw_i[0];
            step(5);
        end
        kif.key_raw_i[0] = 1'b1;
        t0 = cyc;
        step(60);
        check("bounce_count", pulse_cnt - p0, 1);
        check("bounce_idx", last_idx, 0);
        check("bounce_latency", last_cyc - t0, 19);
        kif.key_raw_i = 6'd0;
        step(40);

        // digit 1 and OK together
        p0 = pulse_cnt;
        t0 = cyc;
        kif.key_raw_i = 6'b010010;
        step(40);
        check("simul_count", pulse_cnt - p0, 1);
        check("simul_idx", last_idx, 1);
        check("simul_latency", last_cyc - t0, 19);
        kif.key_raw_i[1] = 1'b0;
        step(40);
        check("simul_no_ok", pulse_cnt - p0, 1);
        check("simul_busy_held", int'(kif.key_busy_o), 1);
        kif.key_raw_i = 6'd0;
        step(40);
        check("simul_busy_free", int'(kif.key_busy_o), 0);

        // door with a short glitch first
        p0 = pulse_cnt;
        d0 = door_rise_cnt;
        kif.door_raw_i = 1'b1;
        step(3);
        kif.door_raw_i = 1'b0;
        step(4);
        kif.door_raw_i = 1'b1;
        t0 = cyc;
        step(40);
        check("door_rise_count", door_rise_cnt - d0, 1);
        check("door_latency", door_rise_cyc - t0, 18);
        check("door_no_keys", pulse_cnt - p0, 0);
        kif.door_raw_i = 1'b0;
        step(30);

        // reset in the middle of a CLEAR debounce
        p0 = pulse_cnt;
        kif.key_raw_i[5] = 1'b1;
        step(10);
        arst_n_i = 1'b0;
        step(1);
        arst_n_i = 1'b1;
        t0 = cyc;
        step(40);
        check("rst_count", pulse_cnt - p0, 1);
        check("rst_idx", last_idx, 5);
        check("rst_latency", last_cyc - t0, 19);
        kif.key_raw_i = 6'd0;
        step(40);

        // long hold of digit 3
        p0 = pulse_cnt;
        s0 = stuck_rise_cnt;
        kif.key_raw_i[3] = 1'b1;
        step(120);
        check("hold_idx", last_idx, 3);
`ifdef KEYPAD_STUCK_DETECT_EN
        check("stuck_rise_count", stuck_rise_cnt - s0, 1);
        check("stuck_delay", stuck_rise_cyc - last_cyc, STUCK);
        check("stuck_high", int'(kif.stuck_o), 1);
`else
        check("stuck_absent", int'(kif.stuck_o), 0);
`endif
        kif.key_raw_i = 6'd0;
        step(40);
        check("hold_release_stuck", int'(kif.stuck_o), 0);
        check("hold_release_busy", int'(kif.key_busy_o), 0);

        // random traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                arst_n_i = 1'b0;
                step(1);
                arst_n_i = 1'b1;
            end else if (r < 40) begin
                kif.key_raw_i[$urandom_range(0, 5)] ^= 1'b1;
            end else if (r < 55) begin
                kif.key_raw_i = 6'($urandom_range(0, 63));
            end else if (r < 70) begin
                kif.door_raw_i = ~kif.door_raw_i;
            end else if (r < 85) begin
                kif.key_raw_i = 6'd0;
            end
            step(int'($urandom_range(1, 40)));
        end
        kif.key_raw_i  = 6'd0;
        kif.door_raw_i = 1'b0;
        step(60);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
